// File: rtl/drop_timer_pkg.sv
// drop_timer_pkg: shared types and default sizing for the drop timer slice.
//   state_e          timer control state (IDLE, RUN, PAUSED)
//   DEF_WIDTH        default counter / top width
//   DEF_LED_BIT      default counter bit routed to the led output
//   DEF_PRESCALE_W   default prescaler width (DROP_TIMER_PRESCALER_EN builds)
package drop_timer_pkg;

  localparam int unsigned DEF_WIDTH      = 25;
  localparam int unsigned DEF_LED_BIT    = 21;
  localparam int unsigned DEF_PRESCALE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

endpackage : drop_timer_pkg

// File: rtl/drop_timer_tick_prescaler.sv
// tick_prescaler: free-running divider that counts 0..div and flags its wrap.
//   clk    clock
//   reset  synchronous, active-low
//   clear  restart the divider at 0 (start/stop/idle)
//   hold   freeze the divider (timer paused)
//   div    terminal value; a tick occurs every div+1 enabled clocks
//   tick   combinational, high in the cycle the divider wraps
module tick_prescaler #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         hold,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         wrap_c;

  assign wrap_c = (cnt_q == div);
  assign tick   = wrap_c & ~hold & ~clear;

  // Divider next value: clear beats hold beats counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = wrap_c ? '0 : W'(cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : tick_prescaler

// File: rtl/drop_timer.sv
// drop_timer: restartable interval timer producing the gravity/drop tick.
// Counts 0..top_q and pulses trigger for one cycle on each wrap. top is
// shadowed into top_q at start and at every wrap, so speed changes only take
// effect on the following period.
//   clk       clock
//   reset     synchronous, active-low
//   start     pulse: latch top/oneshot, clear counter, run
//   stop      pulse: back to idle, clear counter (wins over start)
//   pause     level: hold the counter while running
//   oneshot   mode sampled at start (1 = single period)
//   top       terminal count; period = top+1 count steps
//   prescale  count-step divider (only with DROP_TIMER_PRESCALER_EN)
//   trigger   registered one-cycle pulse on wrap
//   running   registered, high in RUN or PAUSED
//   led       counter bit LED_BIT
//   count     current counter value
// Build option: define DROP_TIMER_PRESCALER_EN to add the prescale port and
// the tick_prescaler stage; otherwise every running clock is a count step.
module drop_timer
  import drop_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned LED_BIT    = DEF_LED_BIT
`ifdef DROP_TIMER_PRESCALER_EN
  ,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  oneshot,
  input  logic [WIDTH-1:0]      top,
`ifdef DROP_TIMER_PRESCALER_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic                  trigger,
  output logic                  running,
  output logic                  led,
  output logic [WIDTH-1:0]      count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             mode_q, mode_d;
  logic             trig_q, trig_d;
  logic             run_q, run_d;

  logic             active_c;
  logic             step_c;
  logic             wrap_c;

  assign active_c = (state_q != ST_IDLE);
  assign wrap_c   = (cnt_q == top_q);

  // A count step happens in RUN, and also on the edge that leaves PAUSED,
  // so a pause of P cycles stretches the period by exactly P cycles.
`ifdef DROP_TIMER_PRESCALER_EN
  logic pre_tick;
  logic pre_clear;

  assign pre_clear = start | stop | ~active_c;

  tick_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (pre_clear),
    .hold  (pause),
    .div   (prescale),
    .tick  (pre_tick)
  );

  assign step_c = active_c & ~pause & pre_tick;
`else
  assign step_c = active_c & ~pause;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop > start > pause > count.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN, ST_PAUSED: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (step_c && wrap_c && mode_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d  = cnt_q;
    top_d  = top_q;
    mode_d = mode_q;
    trig_d = 1'b0;
    run_d  = (state_d != ST_IDLE);
    if (stop) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d  = '0;
      top_d  = top;
      mode_d = oneshot;
    end else if (step_c) begin
      if (wrap_c) begin
        cnt_d  = '0;
        trig_d = 1'b1;
        top_d  = top;
      end else begin
        cnt_d = WIDTH'(cnt_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      top_q  <= '0;
      mode_q <= 1'b0;
      trig_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      top_q  <= top_d;
      mode_q <= mode_d;
      trig_q <= trig_d;
      run_q  <= run_d;
    end
  end

  assign trigger = trig_q;
  assign running = run_q;
  assign count   = cnt_q;
  assign led     = cnt_q[LED_BIT];

endmodule : drop_timer

// File: tb/tb_drop_timer.sv
// tb_drop_timer: randomized and directed stimulus for drop_timer, checked
// every cycle against a period/position reference model.
module tb_drop_timer;

  localparam int unsigned W  = 8;
  localparam int unsigned LB = 2;
`ifdef DROP_TIMER_PRESCALER_EN
  localparam int unsigned PW = 4;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic         stop;
  logic         pause;
  logic         oneshot;
  logic [W-1:0] top;
`ifdef DROP_TIMER_PRESCALER_EN
  logic [PW-1:0] prescale;
`endif
  logic         trigger;
  logic         running;
  logic         led;
  logic [W-1:0] count;

  drop_timer #(
    .WIDTH   (W),
    .LED_BIT (LB)
`ifdef DROP_TIMER_PRESCALER_EN
    ,
    .PRESCALE_W (PW)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .oneshot  (oneshot),
    .top      (top),
`ifdef DROP_TIMER_PRESCALER_EN
    .prescale (prescale),
`endif
    .trigger  (trigger),
    .running  (running),
    .led      (led),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int trig_seen = 0;

  // Reference model: position within the current period, period length,
  // and prescaler phase.
  bit m_run  = 0;
  bit m_once = 0;
  bit m_trig = 0;
  int m_pos  = 0;
  int m_len  = 1;
  int m_ph   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_edge();
    int  div;
    bit  stepping;
`ifdef DROP_TIMER_PRESCALER_EN
    div = int'(prescale);
`else
    div = 0;
`endif
    if (!reset) begin
      m_run = 0; m_once = 0; m_trig = 0; m_pos = 0; m_len = 1; m_ph = 0;
    end else if (stop) begin
      m_run = 0; m_trig = 0; m_pos = 0; m_ph = 0;
    end else if (start) begin
      m_run = 1; m_trig = 0; m_pos = 0; m_ph = 0;
      m_len = int'(top) + 1; m_once = oneshot;
    end else begin
      m_trig = 0;
      if (!m_run) m_ph = 0;
      else if (!pause) begin
        stepping = (m_ph >= div);
        m_ph = stepping ? 0 : m_ph + 1;
        if (stepping) begin
          m_pos = m_pos + 1;
          if (m_pos == m_len) begin
            m_trig = 1; m_pos = 0;
            m_len  = int'(top) + 1;
            if (m_once) m_run = 0;
          end
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("trigger", 32'(trigger), 32'(m_trig));
    check("running", 32'(running), 32'(m_run));
    check("count",   32'(count),   32'(m_pos));
    check("led",     32'(led),     32'((m_pos >> LB) & 1));
    if (trigger) trig_seen++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_start(input logic [W-1:0] t, input logic os);
    top = t; oneshot = os; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    oneshot = 1'b0; top = '0;
`ifdef DROP_TIMER_PRESCALER_EN
    prescale = '0;
`endif
    cycles(3);
    reset = 1'b1;
    cycles(2);

    // Periodic top=4: triggers at 5, 10, 15.
    pulse_start(8'd4, 1'b0);
    trig_seen = 0;
    cycles(15);
    check("periodic_trig_count", 32'(trig_seen), 32'd3);

    // Reset mid-run for 3 cycles, then nothing until the next start.
    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    trig_seen = 0;
    cycles(12);
    check("post_reset_no_trig", 32'(trig_seen), 32'd0);

    // One-shot top=4: exactly one trigger, then idle.
    pulse_start(8'd4, 1'b1);
    trig_seen = 0;
    cycles(14);
    check("oneshot_trig_count", 32'(trig_seen), 32'd1);

    // Periodic top=9, shrink to 2 at count=3: 10-cycle period then 3-cycle.
    pulse_start(8'd9, 1'b0);
    cycles(3);
    top = 8'd2;
    trig_seen = 0;
    cycles(7);
    check("shadow_first_wrap", 32'(trig_seen), 32'd1);
    cycles(9);
    check("shadow_short_periods", 32'(trig_seen), 32'd4);

    // top=5, pause 4 cycles at count=2: trigger at cycle 10.
    pulse_start(8'd5, 1'b0);
    cycles(2);
    pause = 1'b1;
    trig_seen = 0;
    cycles(4);
    pause = 1'b0;
    cycles(3);
    check("pause_no_early_trig", 32'(trig_seen), 32'd0);
    cycles(1);
    check("pause_delayed_trig", 32'(trig_seen), 32'd1);

    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    trig_seen = 0;
    cycles(10);
    check("start_stop_idle", 32'(trig_seen), 32'd0);

    // top=0 periodic: continuous trigger.
    pulse_start(8'd0, 1'b0);
    trig_seen = 0;
    cycles(10);
`ifdef DROP_TIMER_PRESCALER_EN
    check("top0_continuous", 32'(trig_seen), 32'd10);
    // prescale=1, top=3: one trigger every 8 clocks.
    prescale = 4'd1;
    pulse_start(8'd3, 1'b0);
    trig_seen = 0;
    cycles(32);
    check("prescale_period", 32'(trig_seen), 32'd4);
    prescale = '0;
`else
    check("top0_continuous", 32'(trig_seen), 32'd10);
`endif
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Randomized command stream.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 39) == 0);
      stop    = ($urandom_range(0, 79) == 0);
      pause   = ($urandom_range(0, 5) == 0);
      oneshot = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) top = W'($urandom_range(0, 12));
`ifdef DROP_TIMER_PRESCALER_EN
      if ($urandom_range(0, 63) == 0) prescale = PW'($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 499) == 0) reset = 1'b0;
      else reset = 1'b1;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_drop_timer

// File: doc/drop_timer.md
# drop_timer

Parametrised, restartable interval timer generating the gravity/drop tick and auxiliary timing pulses for the game logic. It counts from 0 to a programmable top value and emits a one-cycle trigger on each wrap. It adds periodic/one-shot modes, start/stop/pause control, and a shadowed top value that is reloaded only at wrap so speed changes never glitch a period. It sits between the game controller, which drives top and control, and the piece-movement FSM, which consumes trigger.

## Interface
- WIDTH, 25, counter and top width in bits
- LED_BIT, 21, counter bit routed to led; must satisfy LED_BIT < WIDTH
- PRESCALE_W, 8, prescaler width; used only when DROP_TIMER_PRESCALER_EN is defined

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  pulse; latch top/oneshot, clear counter, enter RUN
- stop  in  1  pulse; return to IDLE, clear counter
- pause  in  1  level; hold counter while high in RUN/PAUSED
- oneshot  in  1  mode sampled at start: 1 = single period, 0 = periodic
- top  in  WIDTH  terminal count; period = top+1 counting cycles
- prescale  in  PRESCALE_W  divide value (only with DROP_TIMER_PRESCALER_EN)
- trigger  out  1  registered one-cycle pulse on wrap
- running  out  1  high in RUN or PAUSED
- led  out  1  counter[LED_BIT]
- count  out  WIDTH  current counter value

## Operation
- States: IDLE, RUN, PAUSED.
- Reset (reset=0 at clk edge): state IDLE; counter, top_q, mode_q, trigger, running all 0; led 0.
- Command priority in every state: stop > start > pause > count.
- stop: go to IDLE, counter←0, trigger←0.
- start (IDLE, RUN or PAUSED): top_q←top, mode_q←oneshot, counter←0, go to RUN, no trigger. Mid-period start is a clean restart.
- RUN with pause=1: go to PAUSED, counter holds. PAUSED with pause=0: go to RUN. Counting resumes on the following count step.
- Count step in RUN: if counter==top_q, then trigger←1, counter←0, and top_q←top (shadow reload). If mode_q=1, go to IDLE. Otherwise counter←counter+1 and trigger←0.
- Trigger is 0 in every cycle not produced by a wrap.
- top changes while running affect only the period after the next wrap.
- top=0, periodic: trigger is high every count step (continuous high without prescaler).
- Counter never exceeds top_q. No wrap past 2^WIDTH−1 is possible.
- IDLE: counter holds 0; pause is ignored.

## Timing
- start sampled at edge e0: count=0 after e0, running=1 after e0.
- count=k after edge ek. Trigger is high for exactly the cycle after edge e(top+1).
- Periodic period = top+1 clocks. Trigger pulses are exactly top+1 cycles apart.
- One-shot: running drops in the same edge that raises trigger.
- stop/start latency: one edge. Outputs are all registered; there is no combinational path from inputs to outputs.
- A pause asserted for P cycles extends the current period by exactly P cycles.

## Configuration
- DROP_TIMER_PRESCALER_EN defined: a prescaler counts 0..prescale and produces a count step on its own wrap. Count steps occur every prescale+1 clocks. The prescaler clears on reset, start and stop, and holds while PAUSED. prescale=0 is equivalent to no prescaler.
- Not defined: prescale port and logic are absent; every clk in RUN is a count step.

## Structure
- Shared package drop_timer_pkg: state enum (IDLE, RUN, PAUSED) and default WIDTH/LED_BIT constants.
- One sub-module, tick_prescaler (clk, reset, clear, hold, div, tick), instantiated only under DROP_TIMER_PRESCALER_EN.

## Test plan
- Reset held low 3 cycles mid-RUN, then released -> state IDLE; trigger, running, count all 0; no trigger until next start.
- top=4, oneshot=0, start -> triggers exactly at cycles 5, 10, 15 after start edge; count sequence 0,1,2,3,4,0.
- top=4, oneshot=1, start -> single trigger at cycle 5, running=0 from same edge, count stays 0 thereafter.
- Periodic top=9, change top to 2 at count=3 -> current period completes at 10 cycles, next periods 3 cycles.
- top=5, pause high 4 cycles at count=2 -> trigger delayed to cycle 10; start and stop asserted together -> IDLE, no trigger.
- With DROP_TIMER_PRESCALER_EN, prescale=1, top=3 -> trigger every 8 clocks; top=0, no prescaler -> trigger continuously high while RUN.
